// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel stream controller and its gradient core.
package sobel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_SLIDE = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SOBEL  = 2'b00;
    localparam logic [1:0] MODE_THRESH = 2'b01;
    localparam logic [1:0] MODE_BYPASS = 2'b10;

    localparam logic [3:0] FILL_SLOTS  = 4'd9;
    localparam logic [3:0] SLIDE_SLOTS = 4'd3;

endpackage

// File: rtl/sobel_grad_core.sv
// Purely combinational 3x3 Sobel magnitude: |Gx|+|Gy| saturated to the pixel range.
module sobel_grad_core
    import sobel_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic [8:0][PIXEL_W-1:0] win_i,
    output logic [PIXEL_W-1:0]      mag_o
);

    localparam int GW = PIXEL_W + 4;
    localparam int MW = PIXEL_W + 5;

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [MW-1:0] abs_ext(input logic signed [GW-1:0] g);
        logic signed [GW-1:0] a;
        a = g[GW-1] ? -g : g;
        return {1'b0, a};
    endfunction

    function automatic logic [PIXEL_W-1:0] sat_pixel(input logic [MW-1:0] m);
        if (m[MW-1:PIXEL_W] != '0) return '1;
        return m[PIXEL_W-1:0];
    endfunction

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [MW-1:0]        mag_sum;

    // Doubling via arithmetic shift stays inside GW: worst case is 4*(2^PIXEL_W-1).
    assign gx = (ext(win_i[2]) + (ext(win_i[5]) <<< 1) + ext(win_i[8]))
              - (ext(win_i[0]) + (ext(win_i[3]) <<< 1) + ext(win_i[6]));
    assign gy = (ext(win_i[6]) + (ext(win_i[7]) <<< 1) + ext(win_i[8]))
              - (ext(win_i[0]) + (ext(win_i[1]) <<< 1) + ext(win_i[2]));

    assign mag_sum = abs_ext(gx) + abs_ext(gy);
    assign mag_o   = sat_pixel(mag_sum);

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Streams 3x3 windows from a serial pixel feed (full fill per strip, 3-pixel slides)
// and emits Sobel / threshold / bypass results with valid-ready handshaking.
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int CNT_W   = 12
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   strip_len_i,
    input  logic [CNT_W-1:0]   strips_i,
    input  logic [1:0]         mode_i,
    input  logic [PIXEL_W-1:0] thresh_i,
    input  logic               px_valid_i,
    input  logic [PIXEL_W-1:0] px_i,
    output logic               in_ready_o,
    output logic               px_valid_o,
    output logic [PIXEL_W-1:0] px_o,
    input  logic               px_ready_i,
    output logic               frame_done_o
);

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    state_t                    state;
    logic [3:0]                slot_cnt;
    logic [CNT_W-1:0]          win_cnt;
    logic [CNT_W-1:0]          strip_cnt;
    logic [CNT_W-1:0]          strip_len_q;
    logic [CNT_W-1:0]          strips_q;
    logic [8:0][PIXEL_W-1:0]   win;
    logic [PIXEL_W-1:0]        mag;
    logic [PIXEL_W-1:0]        result;
    logic                      active;
    logic                      accept;
    logic [CNT_W-1:0]          win_nxt;
    logic [CNT_W-1:0]          strip_nxt;

    // Ready is combinational on px_ready_i so a draining result frees the input the same cycle.
    assign active     = (state == ST_FILL) || (state == ST_SLIDE);
    assign in_ready_o = active && (!px_valid_o || px_ready_i);
    assign accept     = px_valid_i && in_ready_o;
    assign win_nxt    = win_cnt + 1'b1;
    assign strip_nxt  = strip_cnt + 1'b1;

    sobel_grad_core #(.PIXEL_W(PIXEL_W)) u_core (
        .win_i (win),
        .mag_o (mag)
    );

    always_comb begin
        result = mag;
        if ((mode_i & MODE_BYPASS) != 2'b00) begin
            result = win[4];
        end else if (mode_i == MODE_THRESH) begin
            result = (mag >= thresh_i) ? '1 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state        <= ST_IDLE;
            slot_cnt     <= '0;
            win_cnt      <= '0;
            strip_cnt    <= '0;
            strip_len_q  <= '0;
            strips_q     <= '0;
            win          <= '0;
            px_valid_o   <= 1'b0;
            px_o         <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            // A pending result survives an abort; only the handshake or an EMIT reload touches it.
            if (px_valid_o && px_ready_i) begin
                px_valid_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state       <= ST_FILL;
                        strip_len_q <= at_least_one(strip_len_i);
                        strips_q    <= at_least_one(strips_i);
                        slot_cnt    <= '0;
                        win_cnt     <= '0;
                        strip_cnt   <= '0;
                    end
                end

                ST_FILL: begin
                    if (!start_i) begin
                        state     <= ST_IDLE;
                        slot_cnt  <= '0;
                        win_cnt   <= '0;
                        strip_cnt <= '0;
                    end else if (accept) begin
                        win[slot_cnt] <= px_i;
                        if (slot_cnt == FILL_SLOTS - 4'd1) begin
                            slot_cnt <= '0;
                            state    <= ST_EMIT;
                        end else begin
                            slot_cnt <= slot_cnt + 4'd1;
                        end
                    end
                end

                ST_SLIDE: begin
                    if (!start_i) begin
                        state     <= ST_IDLE;
                        slot_cnt  <= '0;
                        win_cnt   <= '0;
                        strip_cnt <= '0;
                    end else if (accept) begin
                        if (slot_cnt == 4'd0) begin
                            win[2:0] <= win[5:3];
                            win[5:3] <= win[8:6];
                            win[6]   <= px_i;
                            slot_cnt <= 4'd1;
                        end else if (slot_cnt == 4'd1) begin
                            win[7]   <= px_i;
                            slot_cnt <= 4'd2;
                        end else begin
                            win[8] <= px_i;
                            if (slot_cnt == SLIDE_SLOTS - 4'd1) begin
                                slot_cnt <= '0;
                                state    <= ST_EMIT;
                            end
                        end
                    end
                end

                ST_EMIT: begin
                    if (!start_i) begin
                        state     <= ST_IDLE;
                        slot_cnt  <= '0;
                        win_cnt   <= '0;
                        strip_cnt <= '0;
                    end else begin
                        px_o       <= result;
                        px_valid_o <= 1'b1;
                        if (win_nxt == strip_len_q) begin
                            win_cnt   <= '0;
                            strip_cnt <= strip_nxt;
                            if (strip_nxt == strips_q) begin
                                state        <= ST_DONE;
                                frame_done_o <= 1'b1;
                            end else begin
                                state <= ST_FILL;
                            end
                        end else begin
                            win_cnt <= win_nxt;
                            state   <= ST_SLIDE;
                        end
                    end
                end

                ST_DONE: begin
                    if (!start_i) begin
                        state     <= ST_IDLE;
                        win_cnt   <= '0;
                        strip_cnt <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl with hand-computed expected results.
module tb_sobel_stream_ctrl;

    localparam int PIXEL_W = 8;
    localparam int CNT_W   = 12;

    logic               clk_i = 1'b0;
    logic               nreset_i = 1'b0;
    logic               start_i = 1'b0;
    logic [CNT_W-1:0]   strip_len_i = '0;
    logic [CNT_W-1:0]   strips_i = '0;
    logic [1:0]         mode_i = 2'b00;
    logic [PIXEL_W-1:0] thresh_i = '0;
    logic               px_valid_i = 1'b0;
    logic [PIXEL_W-1:0] px_i = '0;
    logic               in_ready_o;
    logic               px_valid_o;
    logic [PIXEL_W-1:0] px_o;
    logic               px_ready_i = 1'b1;
    logic               frame_done_o;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [7:0] res_q[$];

    sobel_stream_ctrl #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .start_i      (start_i),
        .strip_len_i  (strip_len_i),
        .strips_i     (strips_i),
        .mode_i       (mode_i),
        .thresh_i     (thresh_i),
        .px_valid_i   (px_valid_i),
        .px_i         (px_i),
        .in_ready_o   (in_ready_o),
        .px_valid_o   (px_valid_o),
        .px_o         (px_o),
        .px_ready_i   (px_ready_i),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshakes and pulses are observed mid-cycle, where inputs and outputs are settled.
    always @(negedge clk_i) begin
        if (nreset_i) begin
            if (px_valid_o && px_ready_i) res_q.push_back(px_o);
            if (frame_done_o) done_cnt++;
            if (px_valid_i && in_ready_o) acc_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res_at(input int i);
        if (i < res_q.size()) return {24'd0, res_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [8:0][7:0] win9(input logic [7:0] a, b, c, d, e, f, g, h, k);
        return {k, h, g, f, e, d, c, b, a};
    endfunction

    function automatic logic [8:0][7:0] rows(input logic [7:0] r0, r1, r2);
        return win9(r0, r0, r0, r1, r1, r1, r2, r2, r2);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_px(input logic [7:0] v);
        int n = 0;
        px_i = v;
        px_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            check_val("send_timeout", {31'd0, in_ready_o}, 32'd1);
            px_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            px_valid_i = 1'b0;
        end
    endtask

    task automatic send_win(input logic [8:0][7:0] p);
        for (int i = 0; i < 9; i++) send_px(p[i]);
    endtask

    task automatic send_rep(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_px(v);
    endtask

    task automatic wait_res(input int n, input string tag);
        int c = 0;
        while (res_q.size() < n && c < 200) begin
            @(posedge clk_i);
            #1;
            c++;
        end
        if (res_q.size() < n) check_val(tag, res_q.size(), n);
    endtask

    task automatic begin_frame(input int len, input int nstrips, input logic [1:0] md, input logic [7:0] thr);
        res_q.delete();
        acc_cnt  = 0;
        done_cnt = 0;
        strip_len_i = CNT_W'(len);
        strips_i    = CNT_W'(nstrips);
        mode_i      = md;
        thresh_i    = thr;
        start_i     = 1'b1;
        tick(1);
    endtask

    task automatic end_frame();
        start_i = 1'b0;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        tick(2);
        check_val("rst_in_ready", {31'd0, in_ready_o}, 0);
        check_val("rst_px_valid", {31'd0, px_valid_o}, 0);
        check_val("rst_px_o", {24'd0, px_o}, 0);
        check_val("rst_frame_done", {31'd0, frame_done_o}, 0);
        nreset_i = 1'b1;
        tick(1);

        // Flat window, single-window frame, latency and done pulse
        px_ready_i = 1'b1;
        begin_frame(1, 1, 2'b00, 8'd0);
        send_rep(8'd50, 9);
        check_val("flat_lat_early", {31'd0, px_valid_o}, 0);
        tick(1);
        check_val("flat_valid", {31'd0, px_valid_o}, 1);
        check_val("flat_px", {24'd0, px_o}, 0);
        check_val("flat_done_pulse", {31'd0, frame_done_o}, 1);
        tick(1);
        check_val("flat_done_low", {31'd0, frame_done_o}, 0);
        check_val("flat_valid_clr", {31'd0, px_valid_o}, 0);
        tick(3);
        check_val("flat_done_cnt", done_cnt, 1);
        check_val("flat_res_cnt", res_q.size(), 1);
        check_val("flat_done_no_ready", {31'd0, in_ready_o}, 0);
        end_frame();

        // Vertical edge: Gx=1020 saturates, bypass gives centre pixel
        begin_frame(1, 1, 2'b00, 8'd0);
        send_win(win9(0, 0, 255, 0, 0, 255, 0, 0, 255));
        wait_res(1, "vedge_wait");
        check_val("vedge_px", res_at(0), 255);
        end_frame();
        begin_frame(1, 1, 2'b10, 8'd0);
        send_win(win9(0, 0, 255, 0, 0, 255, 0, 0, 255));
        wait_res(1, "byp0_wait");
        check_val("bypass_w4_0", res_at(0), 0);
        end_frame();
        begin_frame(1, 1, 2'b11, 8'd0);
        send_win(win9(1, 2, 3, 4, 77, 6, 7, 8, 9));
        wait_res(1, "byp77_wait");
        check_val("bypass_w4_77", res_at(0), 77);
        end_frame();

        // Slide: rows 10/20/30 then row 40 -> both windows Gy=80
        begin_frame(2, 1, 2'b00, 8'd0);
        send_win(rows(10, 20, 30));
        send_rep(8'd40, 3);
        wait_res(2, "slide_wait");
        check_val("slide_res0", res_at(0), 80);
        check_val("slide_res1", res_at(1), 80);
        px_i = 8'd99;
        px_valid_i = 1'b1;
        tick(3);
        px_valid_i = 1'b0;
        check_val("slide_acc_cnt", acc_cnt, 12);
        check_val("slide_done_cnt", done_cnt, 1);
        check_val("slide_res_cnt", res_q.size(), 2);
        end_frame();

        // Backpressure: first result held 5 cycles while the next pixel waits
        px_ready_i = 1'b0;
        begin_frame(2, 1, 2'b00, 8'd0);
        send_win(rows(10, 20, 30));
        tick(1);
        px_i = 8'd90;
        px_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid_hold", {31'd0, px_valid_o}, 1);
            check_val("bp_px_hold", {24'd0, px_o}, 80);
            check_val("bp_in_ready", {31'd0, in_ready_o}, 0);
            tick(1);
        end
        px_ready_i = 1'b1;
        send_rep(8'd90, 3);
        wait_res(2, "bp_wait");
        check_val("bp_res0", res_at(0), 80);
        check_val("bp_res1", res_at(1), 255);
        tick(3);
        check_val("bp_res_cnt", res_q.size(), 2);
        check_val("bp_acc_cnt", acc_cnt, 12);
        check_val("bp_done_cnt", done_cnt, 1);
        end_frame();

        // Threshold 100: magnitudes 60, 120, 100
        begin_frame(3, 1, 2'b01, 8'd100);
        send_win(rows(0, 0, 15));
        send_rep(8'd30, 3);
        send_rep(8'd40, 3);
        wait_res(3, "thr_wait");
        check_val("thr_mag60", res_at(0), 0);
        check_val("thr_mag120", res_at(1), 255);
        check_val("thr_mag100", res_at(2), 255);
        end_frame();

        // Abort after 5 fill pixels, then a restart needs all 9
        begin_frame(1, 1, 2'b00, 8'd0);
        send_rep(8'd50, 5);
        start_i = 1'b0;
        tick(3);
        check_val("abort_valid", {31'd0, px_valid_o}, 0);
        check_val("abort_res_cnt", res_q.size(), 0);
        check_val("abort_done_cnt", done_cnt, 0);
        check_val("abort_in_ready", {31'd0, in_ready_o}, 0);
        begin_frame(1, 1, 2'b00, 8'd0);
        send_rep(8'd50, 8);
        tick(4);
        check_val("restart_8px_no_res", res_q.size(), 0);
        check_val("restart_8px_valid", {31'd0, px_valid_o}, 0);
        send_px(8'd50);
        wait_res(1, "restart_wait");
        check_val("restart_px", res_at(0), 0);
        tick(2);
        check_val("restart_done_cnt", done_cnt, 1);
        end_frame();

        // Asynchronous reset in SLIDE with a result pending
        px_ready_i = 1'b0;
        begin_frame(2, 1, 2'b00, 8'd0);
        send_win(rows(10, 20, 30));
        tick(1);
        check_val("mrst_pre_valid", {31'd0, px_valid_o}, 1);
        @(negedge clk_i);
        #2;
        nreset_i = 1'b0;
        #1;
        check_val("mrst_valid", {31'd0, px_valid_o}, 0);
        check_val("mrst_px_o", {24'd0, px_o}, 0);
        check_val("mrst_in_ready", {31'd0, in_ready_o}, 0);
        check_val("mrst_frame_done", {31'd0, frame_done_o}, 0);
        start_i = 1'b0;
        px_ready_i = 1'b1;
        tick(2);
        nreset_i = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
